// File: rtl/fetch_stage_pkg.sv
// Shared constants, FSM encoding and IF/ID payload type for the fetch stage.
package fetch_stage_pkg;

  localparam logic [31:0] RESET_PC  = 32'h0000_0000;
  localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

  typedef enum logic [1:0] {
    FETCH = 2'd0,
    HELD  = 2'd1,
    DROP  = 2'd2
  } fetch_state_t;

  typedef struct packed {
    logic [31:0] instr;
    logic [31:0] pc;
    logic [31:0] pcp4;
  } fetch_pkt_t;

  function automatic logic [31:0] align4(input logic [31:0] addr);
    return addr & ~32'h0000_0003;
  endfunction

endpackage

// File: rtl/fetch_skid.sv
// One-entry skid buffer holding a fetched instruction that decode could not take.
// Load captures in one cycle; drain or clear empties it, clear winning over load.
module fetch_skid (
  input  logic        clk,
  input  logic        rst,
  input  logic        load,
  input  logic        drain,
  input  logic        clear,
  input  logic [31:0] in_data,
  input  logic [31:0] in_pc,
  input  logic [31:0] in_pcp4,
  output logic [31:0] data,
  output logic [31:0] pc,
  output logic [31:0] pcp4,
  output logic        full
);
  import fetch_stage_pkg::*;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      full <= 1'b0;
      data <= NOP_INSTR;
      pc   <= RESET_PC;
      pcp4 <= RESET_PC;
    end else if (clear || drain) begin
      full <= 1'b0;
    end else if (load) begin
      full <= 1'b1;
      data <= in_data;
      pc   <= in_pc;
      pcp4 <= in_pcp4;
    end
  end

endmodule

// File: rtl/fetch_stage.sv
// Instruction fetch with IF/ID register, stall skid buffer and redirect handling.
// One instruction per cycle with 0-wait memory; a started request is never withdrawn.
module fetch_stage (
  input  logic        clk,
  input  logic        rst,
  input  logic        stall,
  input  logic        pcsrc,
  input  logic [31:0] pctgt,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ready,
  input  logic [31:0] imem_rdata,
  output logic [31:0] instr,
  output logic [31:0] pcd,
  output logic [31:0] pcp4,
  output logic        validd
);
  import fetch_stage_pkg::*;

  fetch_state_t state;
  logic         req;
  logic [31:0]  pc;
  logic [31:0]  tgt;
  fetch_pkt_t   ifid;
  logic         valid_q;

  logic        comp;
  logic [31:0] redir;
  logic [31:0] pc_inc;
  logic        deliver_mem;
  logic        skid_load;
  logic        skid_drain;
  logic [31:0] skid_data;
  logic [31:0] skid_pc;
  logic [31:0] skid_pcp4;
  logic        skid_full;

  assign comp        = req & imem_ready;
  assign redir       = align4(pctgt);
  assign pc_inc      = pc + 32'd4;
  assign deliver_mem = (state == FETCH) && comp && !stall && !pcsrc;
  assign skid_load   = (state == FETCH) && comp && stall && !pcsrc;
  assign skid_drain  = (state == HELD) && skid_full && !stall && !pcsrc;

  assign imem_req  = req;
  assign imem_addr = pc;
  assign instr     = ifid.instr;
  assign pcd       = ifid.pc;
  assign pcp4      = ifid.pcp4;
  assign validd    = valid_q;

  fetch_skid u_skid (
    .clk     (clk),
    .rst     (rst),
    .load    (skid_load),
    .drain   (skid_drain),
    .clear   (pcsrc),
    .in_data (imem_rdata),
    .in_pc   (pc),
    .in_pcp4 (pc_inc),
    .data    (skid_data),
    .pc      (skid_pc),
    .pcp4    (skid_pcp4),
    .full    (skid_full)
  );

  // req is low only out of reset and while parked in HELD
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= FETCH;
      req   <= 1'b0;
    end else begin
      case (state)
        FETCH: begin
          req <= 1'b1;
          if (pcsrc && req && !imem_ready) begin
            state <= DROP;
          end else if (!pcsrc && comp && stall) begin
            state <= HELD;
            req   <= 1'b0;
          end
        end
        HELD: begin
          if (pcsrc || !stall) begin
            state <= FETCH;
            req   <= 1'b1;
          end
        end
        DROP: begin
          if (comp) state <= FETCH;
        end
        default: begin
          state <= FETCH;
          req   <= 1'b1;
        end
      endcase
    end
  end

  // pc drives imem_addr, so a redirect during an open request parks in tgt
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pc  <= RESET_PC;
      tgt <= RESET_PC;
    end else begin
      case (state)
        FETCH: begin
          if (pcsrc) begin
            if (comp || !req) pc  <= redir;
            else              tgt <= redir;
          end else if (comp) begin
            pc <= pc_inc;
          end
        end
        HELD: begin
          if (pcsrc) pc <= redir;
        end
        DROP: begin
          if (pcsrc) tgt <= redir;
          if (comp)  pc  <= pcsrc ? redir : tgt;
        end
        default: pc <= pc;
      endcase
    end
  end

  // Decode consumes whenever stall is low, so an empty cycle becomes a bubble
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ifid    <= '{instr: NOP_INSTR, pc: RESET_PC, pcp4: RESET_PC};
      valid_q <= 1'b0;
    end else if (pcsrc) begin
      ifid.instr <= NOP_INSTR;
      valid_q    <= 1'b0;
    end else if (deliver_mem) begin
      ifid    <= '{instr: imem_rdata, pc: pc, pcp4: pc_inc};
      valid_q <= 1'b1;
    end else if (skid_drain) begin
      ifid    <= '{instr: skid_data, pc: skid_pc, pcp4: skid_pcp4};
      valid_q <= 1'b1;
    end else if (!stall) begin
      ifid.instr <= NOP_INSTR;
      valid_q    <= 1'b0;
    end
  end

endmodule
